// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/BUSY/DONE handshake with a configurable number of wait states.
// Define DMEM_ALIGN_CHK_EN to turn misaligned stores into err pulses instead of writes.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] data_addr,
    input  logic [3:0]  datamem_wr,
    input  logic [7:0]  data_out0,
    input  logic [7:0]  data_out1,
    input  logic [7:0]  data_out2,
    input  logic [7:0]  data_out3,
    output logic [31:0] data_in,
    output logic        ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CNT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] CNT_INIT = 4'(CNT_INIT_I);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   data_in_q, data_in_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          finish;
    logic [AW+1:0] src_addr;
    logic [AW-1:0] src_idx;
    logic [3:0]    src_mask;
    logic [31:0]   src_wdata;
    logic          legal;
    logic          misaligned;
    logic          do_write;
    logic          unused_addr;

    assign accept = (state_q == IDLE) && req;

    // With zero wait states the commit happens on the accepting edge itself,
    // so the access fields come straight from the inputs in that case.
    assign finish = (accept && (WAIT_CYCLES == 0)) ||
                    ((state_q == BUSY) && (cnt_q == 4'd0));

    assign src_addr  = accept ? data_addr[AW+1:0] : addr_q;
    assign src_mask  = accept ? datamem_wr : mask_q;
    assign src_wdata = accept ? {data_out3, data_out2, data_out1, data_out0}
                              : wdata_q;
    assign src_idx   = src_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHK_EN
    // Legal stores: single bytes anywhere, halfwords at 0/2, words at 0.
    always_comb begin
        legal = 1'b0;
        case (src_mask)
            4'b0001: legal = (src_addr[1:0] == 2'd0);
            4'b0010: legal = (src_addr[1:0] == 2'd1);
            4'b0100: legal = (src_addr[1:0] == 2'd2);
            4'b1000: legal = (src_addr[1:0] == 2'd3);
            4'b0011: legal = (src_addr[1:0] == 2'd0);
            4'b1100: legal = (src_addr[1:0] == 2'd2);
            4'b1111: legal = (src_addr[1:0] == 2'd0);
            default: legal = 1'b0;
        endcase
    end
    assign misaligned  = (src_mask != 4'b0000) && !legal;
    assign unused_addr = ^data_addr[31:AW+2];
`else
    assign legal       = 1'b1;
    assign misaligned  = 1'b0;
    assign unused_addr = ^{data_addr[31:AW+2], src_addr[1:0], legal};
`endif

    assign do_write = !rst && finish && (src_mask != 4'b0000) && !misaligned;

    // Next-state, access latching and registered handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        data_in_d = data_in_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = data_addr[AW+1:0];
                    mask_d  = datamem_wr;
                    wdata_d = {data_out3, data_out2, data_out1, data_out0};
                    if (WAIT_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (finish) begin
            ready_d = 1'b1;
            err_d   = misaligned;
            if (src_mask == 4'b0000) begin
                data_in_d = mem[src_idx];
            end
        end
    end

    // FSM and output registers; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            mask_q    <= 4'd0;
            wdata_q   <= 32'd0;
            data_in_q <= 32'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            wdata_q   <= wdata_d;
            data_in_q <= data_in_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    // Byte-lane store into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (src_mask[i]) begin
                    mem[src_idx][8*i +: 8] <= src_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_in = data_in_q;
    assign ready   = ready_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_CYCLES=1, DEPTH_WORDS=1024).
// Works with or without DMEM_ALIGN_CHK_EN defined.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] data_addr;
    logic [3:0]  datamem_wr;
    logic [7:0]  data_out0;
    logic [7:0]  data_out1;
    logic [7:0]  data_out2;
    logic [7:0]  data_out3;
    logic [31:0] data_in;
    logic        ready;
    logic        err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_addr  (data_addr),
        .datamem_wr (datamem_wr),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .data_out2  (data_out2),
        .data_out3  (data_out3),
        .data_in    (data_in),
        .ready      (ready),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access: accept, BUSY, DONE, back to IDLE.
    // Inputs are scrambled after acceptance to show they are ignored.
    task automatic access(input string tag, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] wd,
                          input logic exp_err);
        req        = 1'b1;
        data_addr  = a;
        datamem_wr = m;
        {data_out3, data_out2, data_out1, data_out0} = wd;
        tick();
        req        = 1'b0;
        data_addr  = 32'h0000_0030;
        datamem_wr = 4'hF;
        {data_out3, data_out2, data_out1, data_out0} = 32'hFFFF_FFFF;
        chk({tag, "_busy_rdy"}, {31'd0, ready}, 32'd0);
        tick();
        chk({tag, "_done_rdy"}, {31'd0, ready}, 32'd1);
        chk({tag, "_done_err"}, {31'd0, err}, {31'd0, exp_err});
        tick();
        chk({tag, "_idle_rdy"}, {31'd0, ready}, 32'd0);
        datamem_wr = 4'h0;
    endtask

    initial begin
        rst        = 1'b1;
        req        = 1'b0;
        data_addr  = 32'd0;
        datamem_wr = 4'd0;
        data_out0  = 8'd0;
        data_out1  = 8'd0;
        data_out2  = 8'd0;
        data_out3  = 8'd0;
        tick();
        tick();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_data", data_in, 32'd0);
        rst = 1'b0;
        tick();

        // full word write then read
        access("wr10", 32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        chk("hold_after_wr", data_in, 32'd0);
        access("rd10", 32'h10, 4'b0000, 32'h0, 1'b0);
        chk("rd10_data", data_in, 32'hDEAD_BEEF);

        // single byte lane 2 merge
        access("wr10b", 32'h10, 4'b1111, 32'h1122_3344, 1'b0);
        chk("hold_wr10b", data_in, 32'hDEAD_BEEF);
        access("wr12", 32'h12, 4'b0100, 32'h005A_0000, 1'b0);
        access("rd10b", 32'h10, 4'b0000, 32'h0, 1'b0);
        chk("lane2_merge", data_in, 32'h115A_3344);

        // address aliasing and ignored low address bits on reads
        access("wr0", 32'h0, 4'b1111, 32'hCAFE_F00D, 1'b0);
        access("rd1000", 32'h1000, 4'b0000, 32'h0, 1'b0);
        chk("alias_1000", data_in, 32'hCAFE_F00D);
        access("rd1003", 32'h1003, 4'b0000, 32'h0, 1'b0);
        chk("alias_1003", data_in, 32'hCAFE_F00D);

        // reset in BUSY drops the store
        access("wr20", 32'h20, 4'b1111, 32'hAAAA_5555, 1'b0);
        req        = 1'b1;
        data_addr  = 32'h20;
        datamem_wr = 4'b1111;
        {data_out3, data_out2, data_out1, data_out0} = 32'h1234_5678;
        tick();
        req = 1'b0;
        datamem_wr = 4'b0000;
        chk("acc_busy_rdy", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rdy", {31'd0, ready}, 32'd0);
        chk("midrst_data", data_in, 32'd0);
        tick();
        chk("midrst_rdy2", {31'd0, ready}, 32'd0);
        tick();
        chk("midrst_rdy3", {31'd0, ready}, 32'd0);
        access("rd20", 32'h20, 4'b0000, 32'h0, 1'b0);
        chk("rst_no_commit", data_in, 32'hAAAA_5555);

        // reset wins over req on the same edge
        rst        = 1'b1;
        req        = 1'b1;
        data_addr  = 32'h20;
        datamem_wr = 4'b1111;
        {data_out3, data_out2, data_out1, data_out0} = 32'h0BAD_0BAD;
        tick();
        rst = 1'b0;
        req = 1'b0;
        datamem_wr = 4'b0000;
        tick();
        chk("rst_pri_rdy1", {31'd0, ready}, 32'd0);
        tick();
        chk("rst_pri_rdy2", {31'd0, ready}, 32'd0);
        access("rd20b", 32'h20, 4'b0000, 32'h0, 1'b0);
        chk("rst_pri_mem", data_in, 32'hAAAA_5555);

        // req held high: ready on every third cycle
        req        = 1'b1;
        data_addr  = 32'h10;
        datamem_wr = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("burst_rdy_%0d", k), {31'd0, ready},
                (k % 3 == 2) ? 32'd1 : 32'd0);
            chk($sformatf("burst_dat_%0d", k), data_in,
                (k < 2) ? 32'hAAAA_5555 : 32'h115A_3344);
        end
        req = 1'b0;
        tick();
        chk("burst_tail_rdy", {31'd0, ready}, 32'd1);
        tick();
        chk("burst_end_rdy", {31'd0, ready}, 32'd0);

        // halfword store at an odd address
`ifdef DMEM_ALIGN_CHK_EN
        access("mis21", 32'h21, 4'b0011, 32'h9988_7766, 1'b1);
        access("rd20c", 32'h20, 4'b0000, 32'h0, 1'b0);
        chk("mis_word", data_in, 32'hAAAA_5555);
`else
        access("mis21", 32'h21, 4'b0011, 32'h9988_7766, 1'b0);
        access("rd20c", 32'h20, 4'b0000, 32'h0, 1'b0);
        chk("mis_word", data_in, 32'hAAAA_7766);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra wait states per access (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  1  access request from core.
REQ-006 SHALL have port data_addr  input  32  byte address.
REQ-007 SHALL have port datamem_wr  input  4  byte-lane write mask; 0000 means read.
REQ-008 SHALL have ports data_out0..data_out3  input  8 each  write byte for lanes 0..3.
REQ-009 SHALL have port data_in  output  32  read data to core.
REQ-010 SHALL have port ready  output  1  one-cycle access-complete pulse.
REQ-011 SHALL have port err  output  1  misaligned-store flag, valid with ready.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE with req=1 at an edge SHALL accept: latch address, mask, write bytes; go to BUSY if WAIT_CYCLES>0, else DONE.
REQ-014 BUSY SHALL load counter with WAIT_CYCLES-1 on entry, decrement each cycle, go to DONE on the edge where counter is 0.
REQ-015 Inputs SHALL be ignored outside the accepting IDLE edge; changes during BUSY/DONE have no effect.
REQ-016 Write commit and read capture SHALL occur on the edge entering DONE, using latched values.
REQ-017 Word index SHALL be latched data_addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored (aliasing wrap-around).
REQ-018 Write: lane i with mask bit i set SHALL store data_outi into bits [8i+7:8i]; unset lanes unchanged.
REQ-019 Read (mask 0000): data_in SHALL be loaded with the full addressed word; data_addr[1:0] ignored.
REQ-020 data_in SHALL hold its value through writes and idle cycles until the next read completes.
REQ-021 ready SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL always return to IDLE.
REQ-022 Latency: ready high exactly WAIT_CYCLES+1 cycles after the accepting edge; throughput one access per WAIT_CYCLES+2 cycles.
REQ-023 req high in DONE SHALL be ignored; req still high in the following IDLE cycle SHALL be a new access.
REQ-024 A read of a word written by the previous access SHALL return the new data.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, counter 0, ready 0, err 0, data_in 0x00000000.
REQ-026 rst mid-access SHALL drop the pending access; no write commits, no ready pulse.
REQ-027 Memory array contents SHALL NOT be cleared by reset.
REQ-028 rst SHALL take priority over req on the same edge.

Configuration
REQ-029 Macro DMEM_ALIGN_CHK_EN SHALL enable store alignment checking.
REQ-030 With DMEM_ALIGN_CHK_EN: legal store pairs are mask 0001/0010/0100/1000 with addr[1:0]=0/1/2/3, 0011 with 0, 1100 with 2, 1111 with 0.
REQ-031 With DMEM_ALIGN_CHK_EN: any other nonzero mask/address pair SHALL suppress the write and set err=1 during the ready cycle; err 0 otherwise.
REQ-032 Without DMEM_ALIGN_CHK_EN: err SHALL be tied 0; every nonzero mask writes per REQ-018 regardless of addr[1:0].

Verification (WAIT_CYCLES=1, DEPTH_WORDS=1024)
REQ-033 Write 0xDEADBEEF mask 1111 addr 0x10, then read addr 0x10 -> data_in 0xDEADBEEF; ready 2 cycles after each accept.
REQ-034 Write mask 0100 byte 0x5A addr 0x12 over 0x11223344 -> read 0x115A3344.
REQ-035 Write 0xCAFEF00D addr 0x0 then read addr 0x1000 (alias) -> 0xCAFEF00D.
REQ-036 Accept write 0x12345678 addr 0x20, assert rst in BUSY -> no ready pulse; read 0x20 returns prior contents; data_in 0 right after reset.
REQ-037 req held high 10 cycles -> ready pulses every 3 cycles; data_in stable between reads.
REQ-038 With DMEM_ALIGN_CHK_EN, mask 0011 addr 0x21 -> err=1 with ready, word unchanged; without macro -> err=0, lanes 0-1 written.
